// File: rtl/rename_maptable.sv
// rename_maptable: N-way speculative register rename stage.
// Translates up to N in-order instructions' architectural sources and
// destinations into physical tags each cycle. Holds the speculative map and
// per-physical-register ready bits, and restores from the committed map on a
// mispredict pulse.
//
// Ports:
//   clock, reset_n          clock, asynchronous active-low reset
//   disp_valid[N]           lane valid, contiguous from lane 0
//   src1/src2/dest_arch     N x 5 architectural indices
//   dest_wr[N]              instruction writes dest_arch
//   rob_space               downstream slots free this cycle
//   AllocReqMask[N]         lanes taking a freelist tag (to freelist)
//   FreeReg                 N x TW next free tags from freelist
//   FreeSlotsForN           tags available, min(N, free)
//   disp_accept             number of leading lanes renamed this cycle
//   src1/src2_tag, _ready   renamed source tags and availability
//   dest_tag, told_tag      new physical destination, previous mapping
//   cdb_valid, cdb_tag      completion broadcast
//   BPRecoverEN             mispredict recovery pulse
//   archi_maptable          committed architectural map (ARCH_COUNT x TW)
module rename_maptable #(
    parameter int unsigned N          = 2,
    parameter int unsigned PR_COUNT   = 64,
    parameter int unsigned ARCH_COUNT = 32
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [N-1:0]                     disp_valid,
    input  logic [N*5-1:0]                   src1_arch,
    input  logic [N*5-1:0]                   src2_arch,
    input  logic [N*5-1:0]                   dest_arch,
    input  logic [N-1:0]                     dest_wr,
    input  logic [$clog2(N+1)-1:0]           rob_space,
    output logic [N-1:0]                     AllocReqMask,
    input  logic [N*$clog2(PR_COUNT)-1:0]    FreeReg,
    input  logic [$clog2(N+1)-1:0]           FreeSlotsForN,
    output logic [$clog2(N+1)-1:0]           disp_accept,
    output logic [N*$clog2(PR_COUNT)-1:0]    src1_tag,
    output logic [N*$clog2(PR_COUNT)-1:0]    src2_tag,
    output logic [N-1:0]                     src1_ready,
    output logic [N-1:0]                     src2_ready,
    output logic [N*$clog2(PR_COUNT)-1:0]    dest_tag,
    output logic [N*$clog2(PR_COUNT)-1:0]    told_tag,
    input  logic [N-1:0]                     cdb_valid,
    input  logic [N*$clog2(PR_COUNT)-1:0]    cdb_tag,
    input  logic                             BPRecoverEN,
    input  logic [ARCH_COUNT*$clog2(PR_COUNT)-1:0] archi_maptable
);

    localparam int unsigned TW = $clog2(PR_COUNT);
    localparam int unsigned CW = $clog2(N+1);
    localparam int unsigned AW = 5;

    logic [TW-1:0]       map_q [ARCH_COUNT];
    logic [TW-1:0]       map_d [ARCH_COUNT];
    logic [PR_COUNT-1:0] ready_q;
    logic [PR_COUNT-1:0] ready_d;

    logic [N-1:0]         wr_c;
    logic [N-1:0]         acc_c;
    logic [N-1:0]         alloc_c;
    logic [N-1:0][TW-1:0] new_tag_c;
    logic [CW-1:0]        acc_cnt_c;

    // Prefix acceptance and freelist tag assignment. Tag selection never
    // feeds back into the mask, so FreeReg has no path to AllocReqMask.
    always_comb begin : accept_alloc
        logic          ok;
        logic [CW-1:0] need;
        logic [CW-1:0] kidx;
        wr_c      = '0;
        acc_c     = '0;
        alloc_c   = '0;
        new_tag_c = '0;
        acc_cnt_c = '0;
        ok        = 1'b1;
        need      = '0;
        kidx      = '0;
        for (int i = 0; i < N; i++) begin
            wr_c[i]    = dest_wr[i] && (dest_arch[i*AW +: AW] != '0);
            need       = need + CW'(wr_c[i]);
            acc_c[i]   = ok && disp_valid[i] && (CW'(i) < rob_space) &&
                         (need <= FreeSlotsForN) && !BPRecoverEN;
            ok         = acc_c[i];
            alloc_c[i] = acc_c[i] && wr_c[i];
            if (wr_c[i] && (kidx < CW'(N))) begin
                new_tag_c[i] = FreeReg[kidx*TW +: TW];
            end
            if (wr_c[i]) begin
                kidx = kidx + CW'(1);
            end
            acc_cnt_c = acc_cnt_c + CW'(acc_c[i]);
        end
    end

    assign disp_accept  = reset_n ? acc_cnt_c : '0;
    assign AllocReqMask = reset_n ? alloc_c   : '0;

    // Source/told lookup; k = 0: src1, 1: src2, 2: dest (told).
    // Youngest older allocating lane in the bundle overrides the map.
    always_comb begin : rename_lookup
        logic [AW-1:0] arch;
        logic [TW-1:0] tag;
        logic          rdy;
        src1_tag   = '0;
        src2_tag   = '0;
        src1_ready = '0;
        src2_ready = '0;
        dest_tag   = '0;
        told_tag   = '0;
        arch       = '0;
        tag        = '0;
        rdy        = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 3; k++) begin
                if (k == 0)      arch = src1_arch[i*AW +: AW];
                else if (k == 1) arch = src2_arch[i*AW +: AW];
                else             arch = dest_arch[i*AW +: AW];
                tag = map_q[arch];
                rdy = ready_q[tag];
                for (int c = 0; c < N; c++) begin
                    if (cdb_valid[c] && (cdb_tag[c*TW +: TW] == tag)) rdy = 1'b1;
                end
                for (int j = 0; j < i; j++) begin
                    if (alloc_c[j] && (dest_arch[j*AW +: AW] == arch)) begin
                        tag = new_tag_c[j];
                        rdy = 1'b0;
                    end
                end
                // r0 is hardwired: tag 0, always ready.
                if (arch == '0) begin
                    tag = '0;
                    rdy = 1'b1;
                end
                if (k == 0) begin
                    src1_tag[i*TW +: TW] = tag;
                    src1_ready[i]        = rdy;
                end else if (k == 1) begin
                    src2_tag[i*TW +: TW] = tag;
                    src2_ready[i]        = rdy;
                end else begin
                    told_tag[i*TW +: TW] = tag;
                end
            end
            dest_tag[i*TW +: TW] = new_tag_c[i];
        end
        if (!reset_n) begin
            src1_tag   = '0;
            src2_tag   = '0;
            dest_tag   = '0;
            told_tag   = '0;
            src1_ready = '1;
            src2_ready = '1;
        end
    end

    // Next map/ready state; the clear loop runs after the CDB set loop so a
    // same-tag clear wins.
    always_comb begin : next_state
        map_d   = map_q;
        ready_d = ready_q;
        if (BPRecoverEN) begin
            for (int r = 0; r < ARCH_COUNT; r++) begin
                map_d[r] = archi_maptable[r*TW +: TW];
            end
            ready_d = '1;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (alloc_c[i]) map_d[dest_arch[i*AW +: AW]] = new_tag_c[i];
            end
            for (int c = 0; c < N; c++) begin
                if (cdb_valid[c]) ready_d[cdb_tag[c*TW +: TW]] = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (alloc_c[i]) ready_d[new_tag_c[i]] = 1'b0;
            end
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < ARCH_COUNT; r++) begin
                map_q[r] <= TW'(r);
            end
            ready_q <= '1;
        end else begin
            map_q   <= map_d;
            ready_q <= ready_d;
        end
    end

endmodule
